spi_cs_sequencer: RTL

// Transaction sequencer in front of SPI_Master in the peripheral unit. Buffers host TX words
// and config, drives the master's wr_cr/wr_data/TX_DV strobes with safe spacing for its 2-flop

---
 rtl/spi_cs_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer: transaction sequencer sitting in front of SPI_Master.
// Buffers host TX words and a config shadow, issues wr_cr / wr_data / TX_DV
// strobes spaced four cycles apart so the master's 2-flop edge detectors
// always see a clean edge, owns the chip-selects with programmable
// setup/hold gaps, and queues received words for the host.
//
// Optional feature: define SPI_SEQ_TIMEOUT_EN to add a 20-bit watchdog over
// WAIT_BUSY/WAIT_DONE plus the sticky o_timeout output. Without it the wait
// states wait indefinitely and o_timeout does not exist.

// Small show-ahead FIFO used for both the TX and RX queues.
module spi_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // A push at full is dropped even when a pop happens in the same cycle.
  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];

  // Storage write; left unreset so it maps onto plain RAM.
  always_ff @(posedge i_Clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of 2 depth).
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module spi_cs_sequencer #(
  parameter int  FIFO_DEPTH = 4,
  parameter int  NUM_CS     = 2,
  localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_cfg_wr,
  input  logic [1:0]        i_spi_mode,
  input  logic [15:0]       i_ticks_per_half_bit,
  input  logic [3:0]        i_data_length,
  input  logic              i_tx_msb_first,
  input  logic              i_rx_msb_first,
  input  logic [CS_W-1:0]   i_cs_sel,
  input  logic [7:0]        i_cs_setup,
  input  logic [7:0]        i_cs_hold,
  input  logic              i_tx_push,
  input  logic [15:0]       i_tx_word,
  input  logic              i_tx_last,
  output logic              o_tx_full,
  input  logic              i_rx_pop,
  output logic [15:0]       o_rx_word,
  output logic              o_rx_empty,
  input  logic              i_clr_status,
  output logic              o_rx_overflow,
  output logic              o_busy,
  output logic              o_wr_cr,
  output logic              o_wr_data,
  output logic [1:0]        o_spi_mode,
  output logic [15:0]       o_ticks_per_half_bit,
  output logic [3:0]        o_data_length,
  output logic              o_tx_msb_first,
  output logic              o_rx_msb_first,
  output logic [15:0]       o_TX_Data,
  output logic              o_TX_DV,
  input  logic              i_TX_Ready,
  input  logic              i_RX_DV,
  input  logic [15:0]       i_RX_Data,
  output logic [NUM_CS-1:0] o_SPI_CS_n
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  output logic              o_timeout
`endif
);
  // Strobe plus three quiet cycles so the master's edge detector re-arms.
  localparam logic [7:0] SYNC_GAP = 8'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_CS_SETUP,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_STALL,
    ST_CS_HOLD
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [NUM_CS-1:0] cs_n_reg, cs_n_next;
  logic [NUM_CS-1:0] cs_onehot;
  logic [15:0]       tx_data_reg, tx_data_next;
  logic              tx_last_reg, tx_last_next;

  // Config shadow
  logic [1:0]        cfg_mode_reg;
  logic [15:0]       cfg_ticks_reg;
  logic [3:0]        cfg_len_reg;
  logic              cfg_tx_msb_reg;
  logic              cfg_rx_msb_reg;
  logic [CS_W-1:0]   cfg_cs_sel_reg;
  logic [7:0]        cfg_setup_reg;
  logic [7:0]        cfg_hold_reg;

  logic              tx_empty;
  logic              tx_pop;
  logic              tx_flush;
  logic              do_load;
  logic [16:0]       tx_head;
  logic              rx_full;
  logic              rx_push;
  logic [15:0]       rx_mask;
  logic              rx_overflow_reg;
  logic              wr_cr, wr_data, tx_dv;
  logic [7:0]        setup_lim, hold_lim;
  logic              in_wait;
  logic              wd_expired;

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(17)) u_tx_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .flush   (tx_flush),
    .push    (i_tx_push),
    .wdata   ({i_tx_last, i_tx_word}),
    .pop     (tx_pop),
    .rdata   (tx_head),
    .full    (o_tx_full),
    .empty   (tx_empty)
  );

  // Received words are trimmed to the configured word length before queuing.
  assign rx_mask = 16'hFFFF >> (4'd15 - cfg_len_reg);
  assign rx_push = i_RX_DV && (state_reg != ST_IDLE);

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_rx_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .flush   (1'b0),
    .push    (rx_push),
    .wdata   (i_RX_Data & rx_mask),
    .pop     (i_rx_pop),
    .rdata   (o_rx_word),
    .full    (rx_full),
    .empty   (o_rx_empty)
  );

  // Chip-select decode of the shadowed CS index (out-of-range selects nothing).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_onehot[gi] = (cfg_cs_sel_reg == CS_W'(gi));
    end
  endgenerate

  // Zero setup/hold still gives one cycle of separation.
  assign setup_lim = (cfg_setup_reg == 8'd0) ? 8'd1 : cfg_setup_reg;
  assign hold_lim  = (cfg_hold_reg  == 8'd0) ? 8'd1 : cfg_hold_reg;
  assign in_wait   = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_DONE);

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [19:0] wd_cnt_reg;
  logic        timeout_reg;

  assign wd_expired = in_wait && (wd_cnt_reg == 20'hFFFFF);
  assign o_timeout  = timeout_reg;

  // Watchdog: counts consecutive cycles spent waiting on the master.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (in_wait && !wd_expired) begin
        wd_cnt_reg <= wd_cnt_reg + 20'd1;
      end else begin
        wd_cnt_reg <= '0;
      end
      if (wd_expired) begin
        timeout_reg <= 1'b1;
      end else if (i_clr_status) begin
        timeout_reg <= 1'b0;
      end
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Config shadow: only updated between transactions.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cfg_mode_reg   <= '0;
      cfg_ticks_reg  <= '0;
      cfg_len_reg    <= '0;
      cfg_tx_msb_reg <= 1'b0;
      cfg_rx_msb_reg <= 1'b0;
      cfg_cs_sel_reg <= '0;
      cfg_setup_reg  <= '0;
      cfg_hold_reg   <= '0;
    end else if (i_cfg_wr && (state_reg == ST_IDLE)) begin
      cfg_mode_reg   <= i_spi_mode;
      cfg_ticks_reg  <= i_ticks_per_half_bit;
      cfg_len_reg    <= i_data_length;
      cfg_tx_msb_reg <= i_tx_msb_first;
      cfg_rx_msb_reg <= i_rx_msb_first;
      cfg_cs_sel_reg <= i_cs_sel;
      cfg_setup_reg  <= i_cs_setup;
      cfg_hold_reg   <= i_cs_hold;
    end
  end

  // Sticky RX overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_overflow_reg <= 1'b0;
    end else if (rx_push && rx_full) begin
      rx_overflow_reg <= 1'b1;
    end else if (i_clr_status) begin
      rx_overflow_reg <= 1'b0;
    end
  end

  // FSM state register plus the registered CS and TX word outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      cs_n_reg    <= '1;
      tx_data_reg <= '0;
      tx_last_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cs_n_reg    <= cs_n_next;
      tx_data_reg <= tx_data_next;
      tx_last_reg <= tx_last_next;
    end
  end

  // FSM next-state and strobe decode.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 8'd1;
    cs_n_next    = cs_n_reg;
    tx_data_next = tx_data_reg;
    tx_last_next = tx_last_reg;
    tx_pop       = 1'b0;
    tx_flush     = 1'b0;
    do_load      = 1'b0;
    wr_cr        = 1'b0;
    wr_data      = 1'b0;
    tx_dv        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!tx_empty) begin
          state_next = ST_CFG;
        end
      end
      ST_CFG: begin
        wr_cr = (cnt_reg == 8'd0);
        if (cnt_reg == SYNC_GAP - 8'd1) begin
          state_next = ST_CS_SETUP;
          cnt_next   = '0;
          cs_n_next  = ~cs_onehot;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_reg == setup_lim - 8'd1) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
          do_load    = 1'b1;
        end
      end
      ST_LOAD: begin
        wr_data = (cnt_reg == 8'd0);
        if (cnt_reg == SYNC_GAP - 8'd1) begin
          state_next = ST_START;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        tx_dv      = 1'b1;
        state_next = ST_WAIT_BUSY;
        cnt_next   = '0;
      end
      ST_WAIT_BUSY: begin
        if (!i_TX_Ready) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_TX_Ready) begin
          cnt_next = '0;
          if (tx_last_reg) begin
            state_next = ST_CS_HOLD;
          end else if (!tx_empty) begin
            state_next = ST_LOAD;
            do_load    = 1'b1;
          end else begin
            state_next = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        cnt_next = '0;
        if (!tx_empty) begin
          state_next = ST_LOAD;
          do_load    = 1'b1;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_reg == hold_lim - 8'd1) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          cs_n_next  = '1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        cs_n_next  = '1;
      end
    endcase

    // A stuck master aborts the transaction and discards queued TX words.
    if (wd_expired) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      cs_n_next  = '1;
      tx_flush   = 1'b1;
      do_load    = 1'b0;
    end

    if (do_load) begin
      tx_pop       = 1'b1;
      tx_data_next = tx_head[15:0];
      tx_last_next = tx_head[16];
    end
  end

  assign o_busy               = (state_reg != ST_IDLE);
  assign o_wr_cr              = wr_cr;
  assign o_wr_data            = wr_data;
  assign o_TX_DV              = tx_dv;
  assign o_TX_Data            = tx_data_reg;
  assign o_SPI_CS_n           = cs_n_reg;
  assign o_rx_overflow        = rx_overflow_reg;
  assign o_spi_mode           = cfg_mode_reg;
  assign o_ticks_per_half_bit = cfg_ticks_reg;
  assign o_data_length        = cfg_len_reg;
  assign o_tx_msb_first       = cfg_tx_msb_reg;
  assign o_rx_msb_first       = cfg_rx_msb_reg;
endmodule
